// File: rtl/intersection_controller.sv
// Four-way traffic light sequencer with left-turn phases, pedestrian walk service
// and emergency-vehicle preemption; all outputs decode from registered state.
module intersection_controller #(
  parameter int T_LEFT  = 5,
  parameter int T_GREEN = 10,
  parameter int T_YEL   = 3,
  parameter int T_RED   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       emergency,
  input  logic       emg_dir,
  input  logic       ped_req_ns,
  input  logic       ped_req_ew,
  output logic [3:0] out_ns,
  output logic [3:0] out_ew,
  output logic       walk_ns,
  output logic       walk_ew,
  output logic [3:0] phase
);

  typedef enum logic [3:0] {
    NS_LEFT  = 4'd0,
    NS_GREEN = 4'd1,
    NS_YEL   = 4'd2,
    RED_A    = 4'd3,
    EW_LEFT  = 4'd4,
    EW_GREEN = 4'd5,
    EW_YEL   = 4'd6,
    RED_B    = 4'd7,
    EMG_HOLD = 4'd8,
    EMG_YEL  = 4'd9,
    EMG_RED  = 4'd10
  } state_t;

  localparam logic [4:0] L_LEFT  = 5'(T_LEFT - 1);
  localparam logic [4:0] L_GREEN = 5'(T_GREEN - 1);
  localparam logic [4:0] L_YEL   = 5'(T_YEL - 1);
  localparam logic [4:0] L_RED   = 5'(T_RED - 1);

  state_t     r_state;
  state_t     w_next;
  logic [4:0] r_cnt;
  logic [4:0] w_last;
  logic       r_pend;
  logic       r_emg_dir_q;
  logic       r_ped_q_ns;
  logic       r_ped_q_ew;
  logic       r_walk_ns;
  logic       r_walk_ew;
  logic       w_det;
  logic       w_pend;
  logic       w_dir;
  logic       w_done;
  logic       w_enter;

  // Live emergency counts as pending in its first cycle; HOLD ignores it.
  assign w_det   = emergency && (r_state != EMG_HOLD);
  assign w_pend  = r_pend || w_det;
  assign w_dir   = w_det ? emg_dir : r_emg_dir_q;
  assign w_done  = (r_cnt == w_last);
  assign w_enter = (w_next != r_state);

  always_comb begin
    w_last = 5'd0;
    case (r_state)
      NS_LEFT,  EW_LEFT:         w_last = L_LEFT;
      NS_GREEN, EW_GREEN:        w_last = L_GREEN;
      NS_YEL,   EW_YEL, EMG_YEL: w_last = L_YEL;
      RED_A,    RED_B,  EMG_RED: w_last = L_RED;
      default:                   w_last = 5'd0;
    endcase
  end

  // Yellow always runs into its all-red clearance; a pending emergency is taken at red.
  always_comb begin
    w_next = r_state;
    case (r_state)
      NS_LEFT:  if (w_pend) w_next = w_dir ? NS_YEL : EMG_HOLD;
                else if (w_done) w_next = NS_GREEN;
      NS_GREEN: if (w_pend) w_next = w_dir ? NS_YEL : EMG_HOLD;
                else if (w_done) w_next = NS_YEL;
      NS_YEL:   if (w_done) w_next = RED_A;
      RED_A:    if (w_done) w_next = w_pend ? EMG_HOLD : EW_LEFT;
      EW_LEFT:  if (w_pend) w_next = w_dir ? EMG_HOLD : EW_YEL;
                else if (w_done) w_next = EW_GREEN;
      EW_GREEN: if (w_pend) w_next = w_dir ? EMG_HOLD : EW_YEL;
                else if (w_done) w_next = EW_YEL;
      EW_YEL:   if (w_done) w_next = RED_B;
      RED_B:    if (w_done) w_next = w_pend ? EMG_HOLD : NS_LEFT;
      EMG_HOLD: if (!emergency) w_next = EMG_YEL;
      EMG_YEL:  if (w_done) w_next = EMG_RED;
      EMG_RED:  if (w_done) w_next = w_pend ? EMG_HOLD :
                                     (r_emg_dir_q ? NS_LEFT : EW_LEFT);
      default:  w_next = NS_LEFT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= NS_LEFT;
      r_cnt       <= 5'd0;
      r_pend      <= 1'b0;
      r_emg_dir_q <= 1'b0;
      r_ped_q_ns  <= 1'b0;
      r_ped_q_ew  <= 1'b0;
      r_walk_ns   <= 1'b0;
      r_walk_ew   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_enter ? 5'd0 : r_cnt + 5'd1;
      if (w_enter && (w_next == EMG_HOLD)) r_pend <= 1'b0;
      else if (w_det)                      r_pend <= 1'b1;
      if (w_det) r_emg_dir_q <= emg_dir;
      if (w_enter && (w_next == NS_GREEN)) begin
        r_walk_ns  <= r_ped_q_ns || ped_req_ns;
        r_ped_q_ns <= 1'b0;
      end else if (ped_req_ns) begin
        r_ped_q_ns <= 1'b1;
      end
      if (w_enter && (w_next == EW_GREEN)) begin
        r_walk_ew  <= r_ped_q_ew || ped_req_ew;
        r_ped_q_ew <= 1'b0;
      end else if (ped_req_ew) begin
        r_ped_q_ew <= 1'b1;
      end
    end
  end

  always_comb begin
    out_ns  = 4'b0001;
    out_ew  = 4'b0001;
    walk_ns = 1'b0;
    walk_ew = 1'b0;
    case (r_state)
      NS_LEFT:  out_ns = 4'b1001;
      NS_GREEN: begin out_ns = 4'b0100; walk_ns = r_walk_ns; end
      NS_YEL:   out_ns = 4'b0010;
      EW_LEFT:  out_ew = 4'b1001;
      EW_GREEN: begin out_ew = 4'b0100; walk_ew = r_walk_ew; end
      EW_YEL:   out_ew = 4'b0010;
      EMG_HOLD: if (r_emg_dir_q) out_ew = 4'b0100; else out_ns = 4'b0100;
      EMG_YEL:  if (r_emg_dir_q) out_ew = 4'b0010; else out_ns = 4'b0010;
      default:  ;
    endcase
  end

  assign phase = r_state;

endmodule

// File: tb/tb_intersection_controller.sv
// Scoreboard bench for intersection_controller: directed per-cycle vectors push the
// expected phase/lights/walk; a monitor pops and compares after every clock edge.
module tb_intersection_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       emergency = 1'b0;
  logic       emg_dir = 1'b0;
  logic       ped_req_ns = 1'b0;
  logic       ped_req_ew = 1'b0;
  logic [3:0] out_ns;
  logic [3:0] out_ew;
  logic       walk_ns;
  logic       walk_ew;
  logic [3:0] phase;

  intersection_controller dut (
    .clk        (clk),
    .rst        (rst),
    .emergency  (emergency),
    .emg_dir    (emg_dir),
    .ped_req_ns (ped_req_ns),
    .ped_req_ew (ped_req_ew),
    .out_ns     (out_ns),
    .out_ew     (out_ew),
    .walk_ns    (walk_ns),
    .walk_ew    (walk_ew),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] id;
    logic [3:0]  ph;
    logic [3:0]  ns;
    logic [3:0]  ew;
    logic        wn;
    logic        we;
  } exp_t;

  exp_t sb[$];
  exp_t m_x;
  int   checks   = 0;
  int   failures = 0;
  int   n_push   = 0;
  logic g_edir   = 1'b0;

  function automatic logic [7:0] lights(input logic [3:0] ph, input logic d);
    case (ph)
      4'd0:    return {4'b1001, 4'b0001};
      4'd1:    return {4'b0100, 4'b0001};
      4'd2:    return {4'b0010, 4'b0001};
      4'd4:    return {4'b0001, 4'b1001};
      4'd5:    return {4'b0001, 4'b0100};
      4'd6:    return {4'b0001, 4'b0010};
      4'd8:    return d ? {4'b0001, 4'b0100} : {4'b0100, 4'b0001};
      4'd9:    return d ? {4'b0001, 4'b0010} : {4'b0010, 4'b0001};
      default: return {4'b0001, 4'b0001};
    endcase
  endfunction

  // Inputs driven here are sampled at the next rising edge; the pushed
  // expectation is what the DUT must show right after that edge.
  task automatic cyc(input logic r, input logic e, input logic d, input logic pn,
                     input logic pe, input logic [3:0] ph, input logic wn, input logic we);
    exp_t       x;
    logic [7:0] l;
    @(negedge clk);
    rst = r; emergency = e; emg_dir = d; ped_req_ns = pn; ped_req_ew = pe;
    l    = lights(ph, g_edir);
    x.id = 16'(n_push);
    x.ph = ph;
    x.ns = l[7:4];
    x.ew = l[3:0];
    x.wn = wn;
    x.we = we;
    n_push++;
    sb.push_back(x);
  endtask

  task automatic runw(input logic [3:0] ph, input int n, input logic wn, input logic we);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ph, wn, we);
  endtask

  task automatic run(input logic [3:0] ph, input int n);
    runw(ph, n, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input int id, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%b exp=%b", name, id, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (sb.size() > 0) begin
      m_x = sb.pop_front();
      chk("phase",   int'(m_x.id), phase,           m_x.ph);
      chk("out_ns",  int'(m_x.id), out_ns,          m_x.ns);
      chk("out_ew",  int'(m_x.id), out_ew,          m_x.ew);
      chk("walk_ns", int'(m_x.id), {3'b0, walk_ns}, {3'b0, m_x.wn});
      chk("walk_ew", int'(m_x.id), {3'b0, walk_ew}, {3'b0, m_x.we});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired pending=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    // Free run: 5/10/3/1/5/10/3/1, NS_LEFT again at cycle 38.
    do_reset();
    run(0, 4); run(1, 10); run(2, 3); run(3, 1);
    run(4, 5); run(5, 10); run(6, 3); run(7, 1);
    run(0, 2);

    // Pedestrian service on both directions, one-shot.
    do_reset();
    run(0, 4); run(1, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
    run(1, 8); run(2, 3); run(3, 1); run(4, 5);
    runw(5, 1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b1);
    runw(5, 8, 1'b0, 1'b1);
    run(6, 3); run(7, 1); run(0, 5);
    runw(1, 10, 1'b1, 1'b0);
    run(2, 3); run(3, 1); run(4, 5);
    run(5, 10); run(6, 1);

    // Cross-direction preemption at NS_GREEN cycle 3, emg_dir change in HOLD ignored.
    g_edir = 1'b1;
    do_reset();
    run(0, 4); run(1, 4);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0);
    run(9, 2); run(10, 1); run(0, 5); run(1, 2);

    // Same-direction preemption during NS_LEFT.
    g_edir = 1'b0;
    do_reset();
    run(0, 1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0);
    run(9, 2); run(10, 1); run(4, 5); run(5, 1);

    // One-cycle emergency pulse during EW_YEL.
    g_edir = 1'b1;
    do_reset();
    run(0, 4); run(1, 10); run(2, 3); run(3, 1);
    run(4, 5); run(5, 10); run(6, 1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd6, 1'b0, 1'b0);
    run(6, 1); run(7, 1); run(8, 1); run(9, 3); run(10, 1); run(0, 2);

    // Reset mid-HOLD with emergency still high wins; no re-entry afterwards.
    g_edir = 1'b0;
    do_reset();
    run(0, 1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    run(0, 4); run(1, 10); run(2, 1);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
